// File: rtl/sfm_pkg.sv
// Shared types and helpers for the softmax streamer TCDM blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfm_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 1;

   // One TCDM response beat as it travels back to the master.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [USER_W-1:0] user;
   } tcdm_resp_t;

   // Word index of a byte address: drop the sub-word offset bits, keep idx_w
   // bits above them. Anything higher is discarded, so addresses wrap.
   function automatic logic [63:0] word_index(input logic [63:0] add,
                                              input int unsigned offs_w,
                                              input int unsigned idx_w);
      logic [63:0] mask;
      mask = (64'd1 << idx_w) - 64'd1;
      return (add >> offs_w) & mask;
   endfunction

endpackage

// File: rtl/sfm_fifo.sv
// Generic first-word-fall-through FIFO; an empty queue passes in_dat straight to the head.
// Latency: 0 cycles when empty, otherwise in order behind earlier entries.
// Backpressure: head holds while out_rdy=0; caller must not push when full unless popping.
module sfm_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat,
   input  logic             out_rdy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] cnt;
   logic             empty;
   logic             store;
   logic             take;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt == '0);
   assign out_vld = !empty || in_vld;
   assign out_dat = empty ? in_dat : mem[rptr];
   // An incoming beat consumed in the same cycle it bypasses never gets stored.
   assign store   = in_vld && !(empty && out_rdy);
   assign take    = !empty && out_rdy;

   // Storage array; contents need no reset, occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[wptr] <= in_dat;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (store) wptr <= inc(wptr);
         if (take)  rptr <= inc(rptr);
         case ({store, take})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sfm_tcdm_delay_line.sv
// Valid/payload shift register carrying responses from grant towards the response queue.
// Latency: DEPTH cycles, fixed.
// Backpressure: none; downstream must always absorb the output.
module sfm_tcdm_delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   // Valid bits are control state and are flushed by reset and clear.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         vld <= '0;
      end else begin
         vld[0] <= in_vld;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   // Payload simply follows the valid bits; stale data is masked by vld.
   always_ff @(posedge clk) begin
      dat[0] <= in_dat;
      for (int i = 1; i < DEPTH; i++) begin
         dat[i] <= dat[i-1];
      end
   end

   assign out_vld = vld[DEPTH-1];
   assign out_dat = dat[DEPTH-1];

endmodule

// File: rtl/sfm_tcdm_responder.sv
// Single-port TCDM target: commits stores / samples loads at grant, returns in-order responses.
// Latency: READ_LATENCY cycles from grant edge to r_valid when the response queue is empty.
// Backpressure: head held under r_ready=0; grant drops once MAX_OUTSTANDING are in flight.
module sfm_tcdm_responder import sfm_pkg::*; #(
   parameter int unsigned DATA_WIDTH      = DATA_W,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned NUM_WORDS       = 1024,
   parameter int unsigned UW              = 1,
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STALL_PERIOD    = 0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 clear_i,
   input  logic                                 tcdm_req_i,
   output logic                                 tcdm_gnt_o,
   input  logic [ADDR_WIDTH-1:0]                tcdm_add_i,
   input  logic                                 tcdm_wen_i,
   input  logic [DATA_WIDTH-1:0]                tcdm_data_i,
   input  logic [DATA_WIDTH/8-1:0]              tcdm_be_i,
   input  logic [UW-1:0]                        tcdm_user_i,
   output logic [DATA_WIDTH-1:0]                tcdm_r_data_o,
   output logic                                 tcdm_r_valid_o,
   output logic [UW-1:0]                        tcdm_r_user_o,
   input  logic                                 tcdm_r_ready_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

   localparam int unsigned BE_W   = DATA_WIDTH / 8;
   localparam int unsigned OFFS_W = $clog2(BE_W);
   localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

   // Same shape as tcdm_resp_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [UW-1:0]         user;
   } resp_t;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
   logic [IDX_W-1:0]      idx;
   logic                  stall;
   logic                  accept;
   logic                  pop;
   logic [OUT_W-1:0]      outstanding;
   resp_t                 req_resp;
   resp_t                 dly_resp;
   logic                  dly_vld;
   resp_t                 head;
   logic                  head_vld;

   assign idx = IDX_W'(word_index(64'(tcdm_add_i), OFFS_W, IDX_W));

   if (STALL_PERIOD == 0) begin : g_no_stall
      assign stall = 1'b0;
   end else begin : g_stall
      localparam int unsigned SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [SC_W-1:0] stall_cnt;

      // Free-running stall phase counter; the last phase blocks grant.
      always_ff @(posedge clk_i) begin
         if (!rst_ni || clear_i) begin
            stall_cnt <= '0;
         end else if (stall_cnt == SC_W'(STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
         end else begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end

      assign stall = (stall_cnt == SC_W'(STALL_PERIOD - 1));
   end

   assign pop        = head_vld && tcdm_r_ready_i;
   // A pop frees a slot in the same cycle, so a full pipe can still accept.
   assign tcdm_gnt_o = tcdm_req_i && !stall &&
                       ((outstanding < OUT_W'(MAX_OUTSTANDING)) || pop);
   assign accept     = tcdm_req_i && tcdm_gnt_o;

   // Byte-masked store commit at the accept edge; memory is never reset.
   always_ff @(posedge clk_i) begin
      if (accept && !tcdm_wen_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (tcdm_be_i[b]) begin
               mem[idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
            end
         end
      end
   end

   // Loads sample the array before this edge's write; stores answer with zero data.
   assign req_resp.data = tcdm_wen_i ? mem[idx] : '0;
   assign req_resp.user = tcdm_user_i;

   sfm_tcdm_delay_line #(
      .DEPTH (READ_LATENCY),
      .WIDTH ($bits(resp_t))
   ) u_delay (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .clear   (clear_i),
      .in_vld  (accept),
      .in_dat  (req_resp),
      .out_vld (dly_vld),
      .out_dat (dly_resp)
   );

   sfm_fifo #(
      .WIDTH ($bits(resp_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_q (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .clear   (clear_i),
      .in_vld  (dly_vld),
      .in_dat  (dly_resp),
      .out_vld (head_vld),
      .out_dat (head),
      .out_rdy (tcdm_r_ready_i)
   );

   // Count of transactions accepted but not yet consumed by the master.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         outstanding <= '0;
      end else if (accept && !pop) begin
         outstanding <= outstanding + 1'b1;
      end else if (!accept && pop) begin
         outstanding <= outstanding - 1'b1;
      end
   end

   assign outstanding_o  = outstanding;
   assign tcdm_r_valid_o = head_vld;
   // Mask the head so idle outputs read as zero rather than stale storage.
   assign tcdm_r_data_o  = head_vld ? head.data : '0;
   assign tcdm_r_user_o  = head_vld ? head.user : '0;

endmodule
